// File: rtl/cache_read_pkg.sv
// Shared types and constants for the L1 cache read-side datapath.
package cache_read_pkg;

  localparam int LINE_BITS = 256;
  localparam int BEAT_BITS = 64;
  localparam int NUM_BEATS = 4;
  localparam int WORD_BITS = 32;

  localparam logic [31:0] LINE_ALIGN_MASK = 32'hFFFF_FFE0;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    FILL  = 2'd2,
    RESP  = 2'd3
  } state_t;

  function automatic logic [31:0] line_base(input logic [31:0] addr);
    return addr & LINE_ALIGN_MASK;
  endfunction

endpackage

// File: rtl/line_assembler.sv
// Collects burst beats into a cache line, or loads a whole line at once on a hit.
module line_assembler
  import cache_read_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 clear,
  input  logic                 load_line,
  input  logic [LINE_BITS-1:0] line_in,
  input  logic                 beat_valid,
  input  logic [BEAT_BITS-1:0] beat_data,
  output logic [LINE_BITS-1:0] line_q,
  output logic                 last_beat
);

  logic [1:0] beat_cnt;

  assign last_beat = beat_valid && (beat_cnt == 2'(NUM_BEATS - 1));

  // Saturates on the final beat; the next burst clears it on FETCH entry.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      beat_cnt <= '0;
    end else if (clear) begin
      beat_cnt <= '0;
    end else if (beat_valid && !last_beat) begin
      beat_cnt <= beat_cnt + 2'd1;
    end
  end

  for (genvar gi = 0; gi < NUM_BEATS; gi++) begin : g_beat
    logic [BEAT_BITS-1:0] beat_reg;

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        beat_reg <= '0;
      end else if (load_line) begin
        beat_reg <= line_in[gi*BEAT_BITS +: BEAT_BITS];
      end else if (beat_valid && (beat_cnt == 2'(gi))) begin
        beat_reg <= beat_data;
      end
    end

    assign line_q[gi*BEAT_BITS +: BEAT_BITS] = beat_reg;
  end

endmodule

// File: rtl/line_read_unit.sv
// Load path of the L1 cache: returns a word from the hitting way, or fetches and fills the line first.
module line_read_unit
  import cache_read_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 mem_read,
  input  logic [31:0]          mem_address,
  input  logic                 hit,
  input  logic                 hit_way,
  input  logic [LINE_BITS-1:0] data_1,
  input  logic [LINE_BITS-1:0] data_2,
  output logic [31:0]          mem_rdata,
  output logic                 mem_resp,
  output logic                 pmem_read,
  output logic [31:0]          pmem_address,
  input  logic [BEAT_BITS-1:0] pmem_rdata,
  input  logic                 pmem_resp,
  output logic [LINE_BITS-1:0] fill_line,
  output logic                 fill_valid
);

  state_t               state_reg;
  state_t               state_next;
  logic [31:0]          addr_q;
  logic [LINE_BITS-1:0] line_q;
  logic                 last_beat;
  logic                 accept;
  logic                 load_line;
  logic                 clear;
  logic                 beat_valid;

  assign accept     = (state_reg == IDLE) && mem_read;
  assign load_line  = accept && hit;
  assign clear      = accept && !hit;
  assign beat_valid = (state_reg == FETCH) && pmem_resp;

  line_assembler u_assembler (
    .clk        (clk),
    .rst        (rst),
    .clear      (clear),
    .load_line  (load_line),
    .line_in    (hit_way ? data_2 : data_1),
    .beat_valid (beat_valid),
    .beat_data  (pmem_rdata),
    .line_q     (line_q),
    .last_beat  (last_beat)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr_q <= '0;
    end else if (accept) begin
      addr_q <= mem_address;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (mem_read) state_next = hit ? RESP : FETCH;
      FETCH:   if (last_beat) state_next = FILL;
      FILL:    state_next = RESP;
      RESP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Outputs depend only on registered state so mem_read never reaches mem_resp combinationally.
  always_comb begin
    mem_resp     = 1'b0;
    mem_rdata    = '0;
    pmem_read    = 1'b0;
    pmem_address = '0;
    fill_valid   = 1'b0;
    fill_line    = '0;
    case (state_reg)
      FETCH: begin
        pmem_read    = 1'b1;
        pmem_address = line_base(addr_q);
      end
      FILL: begin
        fill_valid = 1'b1;
        fill_line  = line_q;
      end
      RESP: begin
        mem_resp  = 1'b1;
        mem_rdata = line_q[{addr_q[4:2], 5'b0} +: WORD_BITS];
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_line_read_unit.sv
// Directed, self-checking bench for line_read_unit: hit table plus miss/reset/repeat sequences.
module tb_line_read_unit;

  logic         clk;
  logic         rst;
  logic         mem_read;
  logic [31:0]  mem_address;
  logic         hit;
  logic         hit_way;
  logic [255:0] data_1;
  logic [255:0] data_2;
  logic [31:0]  mem_rdata;
  logic         mem_resp;
  logic         pmem_read;
  logic [31:0]  pmem_address;
  logic [63:0]  pmem_rdata;
  logic         pmem_resp;
  logic [255:0] fill_line;
  logic         fill_valid;

  int checks;
  int failures;

  line_read_unit dut (
    .clk          (clk),
    .rst          (rst),
    .mem_read     (mem_read),
    .mem_address  (mem_address),
    .hit          (hit),
    .hit_way      (hit_way),
    .data_1       (data_1),
    .data_2       (data_2),
    .mem_rdata    (mem_rdata),
    .mem_resp     (mem_resp),
    .pmem_read    (pmem_read),
    .pmem_address (pmem_address),
    .pmem_rdata   (pmem_rdata),
    .pmem_resp    (pmem_resp),
    .fill_line    (fill_line),
    .fill_valid   (fill_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    logic        way;
    logic [31:0] exp_word;
  } hit_vec_t;

  logic [63:0]  beats [4];
  logic [255:0] exp_line;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk_idle_outputs(input string tag);
    chk({tag, "_mem_resp"}, 256'(mem_resp), 256'(0));
    chk({tag, "_mem_rdata"}, 256'(mem_rdata), 256'(0));
    chk({tag, "_pmem_read"}, 256'(pmem_read), 256'(0));
    chk({tag, "_pmem_address"}, 256'(pmem_address), 256'(0));
    chk({tag, "_fill_valid"}, 256'(fill_valid), 256'(0));
    chk({tag, "_fill_line"}, fill_line, 256'(0));
  endtask

  // Single hit request: accepted at the next edge, response visible right after it.
  task automatic do_hit(input string tag, input logic [31:0] addr, input logic way,
                        input logic [31:0] exp_word);
    mem_read    = 1'b1;
    mem_address = addr;
    hit         = 1'b1;
    hit_way     = way;
    step();
    chk({tag, "_resp"}, 256'(mem_resp), 256'(1));
    chk({tag, "_rdata"}, 256'(mem_rdata), 256'(exp_word));
    mem_read = 1'b0;
    hit      = 1'b0;
    step();
    chk({tag, "_resp_drop"}, 256'(mem_resp), 256'(0));
    $display("hit  %-10s addr=%h way=%0d rdata=%h", tag, addr, way, exp_word);
  endtask

  // Miss with `gap` idle cycles before each beat; optionally drops mem_read early.
  task automatic do_miss(input string tag, input logic [31:0] addr, input int gap,
                         input logic drop_early, input logic [31:0] exp_word,
                         input logic [31:0] exp_paddr);
    mem_read    = 1'b1;
    mem_address = addr;
    hit         = 1'b0;
    hit_way     = 1'b1;
    step();
    if (drop_early) mem_read = 1'b0;
    chk({tag, "_pmem_read_start"}, 256'(pmem_read), 256'(1));
    chk({tag, "_pmem_address"}, 256'(pmem_address), 256'(exp_paddr));
    for (int b = 0; b < 4; b++) begin
      for (int g = 0; g < gap; g++) begin
        pmem_resp  = 1'b0;
        pmem_rdata = 64'hBAD0_BAD0_BAD0_BAD0;
        hit        = 1'b1;
        step();
        chk({tag, "_pmem_read_gap"}, 256'(pmem_read), 256'(1));
        chk({tag, "_fill_gap"}, 256'(fill_valid), 256'(0));
      end
      hit        = 1'b0;
      pmem_resp  = 1'b1;
      pmem_rdata = beats[b];
      chk({tag, "_pmem_read_beat"}, 256'(pmem_read), 256'(1));
      step();
    end
    // Stray beat while in FILL must not touch the assembled line.
    pmem_rdata = 64'hFFFF_FFFF_FFFF_FFFF;
    chk({tag, "_fill_valid"}, 256'(fill_valid), 256'(1));
    chk({tag, "_fill_line"}, fill_line, exp_line);
    chk({tag, "_pmem_read_end"}, 256'(pmem_read), 256'(0));
    chk({tag, "_resp_early"}, 256'(mem_resp), 256'(0));
    step();
    pmem_resp = 1'b0;
    chk({tag, "_resp"}, 256'(mem_resp), 256'(1));
    chk({tag, "_rdata"}, 256'(mem_rdata), 256'(exp_word));
    chk({tag, "_fill_once"}, 256'(fill_valid), 256'(0));
    mem_read = 1'b0;
    step();
    chk({tag, "_resp_drop"}, 256'(mem_resp), 256'(0));
    $display("miss %-10s addr=%h gap=%0d rdata=%h", tag, addr, gap, exp_word);
  endtask

  initial begin
    hit_vec_t vecs [6];
    checks      = 0;
    failures    = 0;
    rst         = 1'b1;
    mem_read    = 1'b0;
    mem_address = '0;
    hit         = 1'b0;
    hit_way     = 1'b0;
    pmem_rdata  = '0;
    pmem_resp   = 1'b0;
    for (int i = 0; i < 8; i++) begin
      data_1[32*i +: 32] = 32'hA000_0000 + 32'(i);
      data_2[32*i +: 32] = 32'hB000_0000 + 32'(i);
    end
    data_2[32*5 +: 32] = 32'hDEAD_BEEF;
    beats[0] = 64'h0706050403020100;
    beats[1] = 64'h0F0E0D0C0B0A0908;
    beats[2] = 64'h1716151413121110;
    beats[3] = 64'h1F1E1D1C1B1A1918;
    exp_line = {beats[3], beats[2], beats[1], beats[0]};

    vecs[0] = '{addr: 32'h0000_0014, way: 1'b1, exp_word: 32'hDEAD_BEEF};
    vecs[1] = '{addr: 32'h0000_0014, way: 1'b0, exp_word: 32'hA000_0005};
    vecs[2] = '{addr: 32'h0000_0000, way: 1'b0, exp_word: 32'hA000_0000};
    vecs[3] = '{addr: 32'h0000_001F, way: 1'b1, exp_word: 32'hB000_0007};
    vecs[4] = '{addr: 32'hFFFF_FFE8, way: 1'b1, exp_word: 32'hB000_0002};
    vecs[5] = '{addr: 32'h0000_000D, way: 1'b0, exp_word: 32'hA000_0003};

    #2;
    chk_idle_outputs("reset");
    step();
    step();
    rst = 1'b0;
    step();
    chk_idle_outputs("post_reset");

    for (int i = 0; i < 6; i++) begin
      do_hit($sformatf("vec%0d", i), vecs[i].addr, vecs[i].way, vecs[i].exp_word);
    end

    do_miss("b2b", 32'h1234_567C, 0, 1'b0, 32'h1F1E_1D1C, 32'h1234_5660);
    do_miss("gaps", 32'h1234_567C, 3, 1'b1, 32'h1F1E_1D1C, 32'h1234_5660);
    do_miss("word0", 32'hCAFE_0043, 1, 1'b0, 32'h0302_0100, 32'hCAFE_0040);

    // Reset after two beats: partial line dropped, stray beats ignored.
    mem_read    = 1'b1;
    mem_address = 32'h0000_1100;
    hit         = 1'b0;
    step();
    chk("rst2_pmem_read", 256'(pmem_read), 256'(1));
    for (int b = 0; b < 2; b++) begin
      pmem_resp  = 1'b1;
      pmem_rdata = beats[b];
      step();
    end
    pmem_resp = 1'b0;
    mem_read  = 1'b0;
    rst       = 1'b1;
    #1;
    chk_idle_outputs("rst_mid");
    step();
    rst = 1'b0;
    for (int k = 0; k < 4; k++) begin
      pmem_resp  = 1'b1;
      pmem_rdata = beats[k];
      step();
      chk("rst2_stray_pmem_read", 256'(pmem_read), 256'(0));
      chk("rst2_stray_fill", 256'(fill_valid), 256'(0));
      chk("rst2_stray_resp", 256'(mem_resp), 256'(0));
    end
    pmem_resp = 1'b0;
    $display("rst  after 2 beats: no fill, stray beats ignored");
    do_hit("post_rst", 32'h0000_0014, 1'b1, 32'hDEAD_BEEF);

    // Repeat request: mem_read held across mem_resp.
    mem_read    = 1'b1;
    mem_address = 32'h0000_0008;
    hit         = 1'b1;
    hit_way     = 1'b0;
    step();
    chk("rep1_resp", 256'(mem_resp), 256'(1));
    chk("rep1_rdata", 256'(mem_rdata), 256'(32'hA000_0002));
    mem_address = 32'h0000_0018;
    hit_way     = 1'b1;
    step();
    chk("rep_gap_resp", 256'(mem_resp), 256'(0));
    step();
    chk("rep2_resp", 256'(mem_resp), 256'(1));
    chk("rep2_rdata", 256'(mem_rdata), 256'(32'hB000_0006));
    mem_read = 1'b0;
    hit      = 1'b0;
    step();
    chk("rep2_resp_drop", 256'(mem_resp), 256'(0));
    $display("rep  two requests with mem_read held high");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1);
  end

endmodule

// File: doc/line_read_unit.md
# line_read_unit

Read-side datapath for the L1 cache: services a CPU load by returning the addressed 32-bit word from a cache line. On a hit the word comes from the hitting way. On a miss the unit fetches the line from physical memory as four 64-bit beats, hands the assembled line to the data arrays for fill, then returns the word. It is the read-direction counterpart of the cache's write-merge logic and sits between the cache control FSM, the way data arrays and the physical-memory port.

## Interface
Parameters:
- none; widths are fixed by package constants LINE_BITS=256, BEAT_BITS=64, NUM_BEATS=4.

Ports (clock and reset first):
- clk  in  1  single clock; all state updates on its rising edge.
- rst  in  1  asynchronous, active-high reset.
- mem_read  in  1  CPU load request; held high until mem_resp.
- mem_address  in  32  CPU byte address; [4:2] is the word offset, [1:0] is ignored.
- hit  in  1  tag match for mem_address, valid in the same cycle as mem_read.
- hit_way  in  1  hitting way: 0 selects data_1, 1 selects data_2.
- data_1, data_2  in  256  way 0 and way 1 line contents.
- mem_rdata  out  32  returned word; valid only while mem_resp=1.
- mem_resp  out  1  one-cycle response pulse.
- pmem_read  out  1  physical-memory burst read request.
- pmem_address  out  32  line-aligned address, {addr[31:5],5'b0}.
- pmem_rdata  in  64  burst beat data.
- pmem_resp  in  1  one pulse per valid beat.
- fill_line  out  256  assembled line for array write.
- fill_valid  out  1  one-cycle array write strobe.

## Operation
- States: IDLE, FETCH, FILL, RESP.
- **IDLE:** when mem_read=1:
  - Latch mem_address into addr_q.
  - If hit=1: latch the selected way line into line_q and go to RESP.
  - If hit=0: clear beat_cnt and go to FETCH.
- **FETCH:** pmem_read=1 and pmem_address={addr_q[31:5],5'b0}.
  - Each pmem_resp=1 writes pmem_rdata into line_q[64*beat_cnt +: 64] and increments beat_cnt.
  - The beat with beat_cnt=3 goes to FILL.
- **FILL:** fill_valid=1 and fill_line=line_q for exactly one cycle, then go to RESP.
- **RESP:** mem_resp=1 and mem_rdata=line_q[32*addr_q[4:2] +: 32] for exactly one cycle, then go to IDLE.
- beat_cnt is 2 bits and never wraps inside a burst; it is cleared on entry to FETCH.
- Outputs are decoded from registered state only; there is no combinational path from mem_read to mem_resp.

## Timing
- Reset values: state=IDLE, beat_cnt=0, line_q=0, addr_q=0. All outputs are 0: mem_resp, mem_rdata, pmem_read, pmem_address, fill_valid, fill_line.
- Hit latency: request accepted in cycle N, mem_resp in cycle N+1.
- Miss latency: 4th pmem_resp in cycle M, fill_valid in M+1, mem_resp in M+2.
- pmem_read stays high continuously from FETCH entry through the cycle of the 4th pmem_resp, then deasserts in M+1.
- pmem_resp outside FETCH is ignored.
- Gaps between beats (pmem_resp=0) hold state and beat_cnt.
- mem_read dropping during FETCH or FILL does not abort: the fill still completes and mem_resp still pulses.
- mem_read still high in the cycle after mem_resp is accepted as a new request; the CPU drops mem_read after mem_resp.
- hit and hit_way are sampled only in IDLE with mem_read=1.
- Asserting rst in any state returns to IDLE immediately and clears beat_cnt.
  - A partial line is discarded and no fill_valid is issued.
  - pmem_read deasserts asynchronously.
  - Beats arriving after reset are ignored.

## Structure
- Shared package cache_read_pkg holds:
  - the state enum (IDLE, FETCH, FILL, RESP);
  - LINE_BITS, BEAT_BITS, NUM_BEATS;
  - the line-alignment mask constant.
- One sub-module, line_assembler, holds beat_cnt, line_q write indexing and the last-beat flag.
  - Inputs: clk, rst, clear, load_line, line_in, beat_valid, beat_data.
  - Outputs: line_q, last_beat.
- The top level holds the FSM, addr_q and the word-select mux.

## Test plan
- **Reset:** assert rst mid-stream -> all outputs 0 and state IDLE in the same cycle; after release, the first hit request responds 1 cycle later.
- **Hit, way 1:** mem_address=0x0000_0014, hit=1, hit_way=1, data_2 word 5=0xDEADBEEF -> mem_resp at N+1 with mem_rdata=0xDEADBEEF. The same stimulus with hit_way=0 returns data_1 word 5.
- **Miss, back-to-back beats:** mem_address=0x1234_567C, hit=0 -> pmem_address=0x1234_5660.
  - Beats 0x0706050403020100, 0x0F0E0D0C0B0A0908, 0x1716151413121110, 0x1F1E1D1C1B1A1918 -> fill_valid with the matching 256-bit line at M+1.
  - mem_resp at M+2 with mem_rdata=0x1F1E1D1C (word 7).
- **Miss with gaps:** insert 3 idle cycles between each beat -> pmem_read held high throughout, beat_cnt frozen during gaps, and the same line and word as the back-to-back case.
- **Reset after 2 beats:** assert rst after 2 of 4 beats -> no fill_valid, pmem_read drops, and stray pmem_resp pulses afterwards are ignored; a following hit request is served normally.
- **Repeat request:** keep mem_read high across mem_resp -> the second request is accepted in IDLE and its own mem_resp arrives one cycle after acceptance.
